// File: rtl/instruction_cache_controller_if.sv
// Fetch-side lookup and instruction-memory refill signals of the instruction cache.
// master: the cache controller (answers fetch, initiates refills).
// slave: the fetch stage plus instruction memory that surround it.
interface instruction_cache_controller_if;
   logic [31:0] fetchPC;
   logic        fetchValid;
   logic [31:0] fetchInstruction;
   logic        fetchReady;
   logic [31:0] memPC;
   logic        memRequest;
   logic [63:0] memCacheData;
   logic        memReceived;

   modport master (
      input  fetchPC, fetchValid, memCacheData, memReceived,
      output fetchInstruction, fetchReady, memPC, memRequest
   );

   modport slave (
      output fetchPC, fetchValid, memCacheData, memReceived,
      input  fetchInstruction, fetchReady, memPC, memRequest
   );
endinterface

// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache (two 32-bit words per line) with refill initiator.
// Latency: hit 0 cycles (combinational); miss 3 cycles plus memory response delay.
// Backpressure: fetchReady stays low through a miss; fetch must hold fetchPC/fetchValid.
module instruction_cache_controller #(
   parameter int numLines = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   instruction_cache_controller_if.master bus,
   output logic [31:0] hitCount,
   output logic [31:0] missCount
);

   localparam int IDX  = $clog2(numLines);
   localparam int TAGW = 32 - IDX - 3;

   typedef enum logic [1:0] {LOOKUP, REQUEST, WAIT} state_t;

   state_t state_q;
   state_t state_d;

   logic [numLines-1:0] valid_q;
   logic [TAGW-1:0]     tag_q  [numLines];
   logic [63:0]         data_q [numLines];

   logic [31:0]     mem_pc_q;
   logic [IDX-1:0]  lookup_idx;
   logic [TAGW-1:0] lookup_tag;
   logic [IDX-1:0]  fill_idx;
   logic [63:0]     lookup_line;
   logic [31:0]     sel_word;
   logic            line_hit;
   logic            refill;

   logic            fetch_ready;
   logic [31:0]     fetch_instr;
   logic            mem_request;
   logic            hit_event;
   logic            miss_event;

   // Byte offset within a word is meaningless for instruction fetch.
   logic            pc_byte_unused;
   assign pc_byte_unused = ^bus.fetchPC[1:0];

   assign lookup_idx  = bus.fetchPC[IDX+2:3];
   assign lookup_tag  = bus.fetchPC[31:IDX+3];
   assign lookup_line = data_q[lookup_idx];
   // Lower address word lives in the upper half of the line.
   assign sel_word    = bus.fetchPC[2] ? lookup_line[31:0] : lookup_line[63:32];
   assign line_hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

   // The refill always targets the registered line address, not the live fetchPC.
   assign fill_idx = mem_pc_q[IDX+2:3];
   assign refill   = (state_q == WAIT) && bus.memReceived && !reset;

   assign bus.fetchReady       = fetch_ready;
   assign bus.fetchInstruction = fetch_instr;
   assign bus.memRequest       = mem_request;
   assign bus.memPC            = mem_pc_q;

   // State register; reset abandons any refill in flight.
   always_ff @(posedge clk) begin
      if (reset) state_q <= LOOKUP;
      else       state_q <= state_d;
   end

   // Next state: miss -> one request cycle -> wait for the response -> lookup again.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOOKUP:  if (bus.fetchValid && !line_hit) state_d = REQUEST;
         REQUEST: state_d = WAIT;
         WAIT:    if (bus.memReceived) state_d = LOOKUP;
         default: state_d = LOOKUP;
      endcase
   end

   // Fetch/memory outputs and counter events, all decoded from the current state.
   always_comb begin
      fetch_ready = 1'b0;
      fetch_instr = '0;
      mem_request = 1'b0;
      hit_event   = 1'b0;
      miss_event  = 1'b0;
      case (state_q)
         LOOKUP: begin
            if (bus.fetchValid) begin
               if (line_hit) begin
                  fetch_ready = 1'b1;
                  fetch_instr = sel_word;
                  hit_event   = 1'b1;
               end else begin
                  miss_event  = 1'b1;
               end
            end
         end
         REQUEST: mem_request = 1'b1;
         default: ;
      endcase
      if (reset) begin
         fetch_ready = 1'b0;
         fetch_instr = '0;
         mem_request = 1'b0;
         hit_event   = 1'b0;
         miss_event  = 1'b0;
      end
   end

   // Line address captured at the miss and held until the next miss.
   always_ff @(posedge clk) begin
      if (reset)           mem_pc_q <= '0;
      else if (miss_event) mem_pc_q <= {bus.fetchPC[31:3], 3'b000};
   end

   // Valid bits: flush wins over a same-cycle refill, so that line stays invalid.
   always_ff @(posedge clk) begin
      if (reset || flush) valid_q <= '0;
      else if (refill)    valid_q[fill_idx] <= 1'b1;
   end

   // Tag and data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (refill) begin
         data_q[fill_idx] <= bus.memCacheData;
         tag_q[fill_idx]  <= mem_pc_q[31:IDX+3];
      end
   end

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         hitCount  <= '0;
         missCount <= '0;
      end else begin
         if (hit_event)  hitCount  <= hitCount + 32'd1;
         if (miss_event) missCount <= missCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Bench for instruction_cache_controller: drives fetch, emulates instruction memory,
// and scoreboards returned instructions and counters.
module tb_instruction_cache_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] hitCount;
   logic [31:0] missCount;

   instruction_cache_controller_if bus();

   instruction_cache_controller #(.numLines(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus),
      .hitCount  (hitCount),
      .missCount (missCount)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_hit = 0;
   int exp_miss = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction memory contents: two fixed words at 0x0/0x4, a pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0)      return 32'h00500113;
      else if (w == 32'h4) return 32'h00300193;
      else                 return w ^ 32'h13570000;
   endfunction

   // Line image as memory returns it: word at line+0 in the upper half.
   function automatic logic [63:0] line_data(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:3], 3'b000};
      return {mem_word(base), mem_word(base + 32'd4)};
   endfunction

   task automatic chk_counts(input string tag);
      chk({tag, "_hits"}, hitCount, 32'(exp_hit));
      chk({tag, "_misses"}, missCount, 32'(exp_miss));
   endtask

   // One fetch: push the expected word, run memory with the given response delay,
   // optionally flush on the first response, pop/compare when fetchReady appears.
   task automatic fetch(input logic [31:0] pc, input int delay, input bit flush_rx,
                        input int exp_req, input int exp_lat, input string tag);
      int  cnt;
      int  nreq;
      int  lat;
      bit  got;
      bit  waiting;
      bit  fl;
      logic [31:0] line;
      line    = {pc[31:3], 3'b000};
      cnt     = -1;
      nreq    = 0;
      lat     = -1;
      got     = 1'b0;
      waiting = 1'b0;
      fl      = flush_rx;
      @(negedge clk);
      bus.fetchPC    = pc;
      bus.fetchValid = 1'b1;
      exp_q.push_back(mem_word(pc));
      for (int c = 0; c < 64 && !got; c++) begin
         #1;
         if (bus.fetchReady) begin
            got = 1'b1;
            lat = c;
            chk({tag, "_instr"}, bus.fetchInstruction, exp_q.pop_front());
         end
         if (waiting) chk({tag, "_memPC_hold"}, bus.memPC, line);
         if (bus.memRequest) begin
            nreq++;
            chk({tag, "_memPC"}, bus.memPC, line);
            cnt = delay;
            waiting = 1'b1;
         end
         @(negedge clk);
         bus.memReceived  = 1'b0;
         bus.memCacheData = '0;
         flush            = 1'b0;
         if (got) begin
            bus.fetchValid = 1'b0;
         end else if (waiting && cnt == 0) begin
            bus.memReceived  = 1'b1;
            bus.memCacheData = line_data(line);
            if (fl) begin
               flush = 1'b1;
               fl    = 1'b0;
            end
            cnt = -1;
            waiting = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
         end
      end
      if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
      chk({tag, "_requests"}, 32'(nreq), 32'(exp_req));
      if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      exp_hit  = exp_hit + 1;
      exp_miss = exp_miss + exp_req;
      chk_counts(tag);
   endtask

   initial begin
      bit seen;
      reset            = 1'b1;
      flush            = 1'b0;
      bus.fetchPC      = '0;
      bus.fetchValid   = 1'b0;
      bus.memCacheData = '0;
      bus.memReceived  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      // Spurious response in the first cycle after reset.
      bus.memReceived  = 1'b1;
      bus.memCacheData = 64'hDEADBEEF_CAFEF00D;
      #1;
      chk("rst_ready", 32'(bus.fetchReady), 32'd0);
      chk("rst_instr", bus.fetchInstruction, 32'd0);
      chk("rst_req", 32'(bus.memRequest), 32'd0);
      chk("rst_memPC", bus.memPC, 32'd0);
      chk_counts("rst");
      @(negedge clk);
      bus.memReceived = 1'b0;

      // Cold miss then same-line hit.
      fetch(32'h0, 2, 1'b0, 1, 5, "cold");
      fetch(32'h4, 0, 1'b0, 0, 0, "same_line");

      // Conflict: 0x40 maps onto line 0 and evicts it.
      fetch(32'h40, 1, 1'b0, 1, 4, "conflict");
      fetch(32'h0, 1, 1'b0, 1, 4, "refetch0");
      chk("conflict_total_miss", missCount, 32'd3);

      // Spurious response in LOOKUP with no fetch pending.
      @(negedge clk);
      bus.fetchValid   = 1'b0;
      bus.memReceived  = 1'b1;
      bus.memCacheData = 64'h11111111_22222222;
      #1;
      chk("spur_ready", 32'(bus.fetchReady), 32'd0);
      chk("spur_req", 32'(bus.memRequest), 32'd0);
      @(negedge clk);
      bus.memReceived = 1'b0;
      chk_counts("spur_idle");
      fetch(32'h8, 0, 1'b0, 1, 3, "after_spur");

      // Flush collides with the refill response: line re-misses, second refill hits.
      fetch(32'h10, 1, 1'b1, 2, -1, "flush_rx");
      fetch(32'h14, 0, 1'b0, 0, 0, "flush_rx_hit");

      // Flush during a hit: hit still reported, line gone afterwards.
      @(negedge clk);
      bus.fetchPC    = 32'h14;
      bus.fetchValid = 1'b1;
      flush          = 1'b1;
      #1;
      chk("flush_hit_ready", 32'(bus.fetchReady), 32'd1);
      chk("flush_hit_instr", bus.fetchInstruction, mem_word(32'h14));
      exp_hit++;
      @(negedge clk);
      flush          = 1'b0;
      bus.fetchValid = 1'b0;
      fetch(32'h14, 0, 1'b0, 1, 3, "post_flush");

      // Reset while waiting for memory, then a late response.
      @(negedge clk);
      bus.fetchPC    = 32'h18;
      bus.fetchValid = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         #1;
         if (bus.memRequest) seen = 1'b1;
         @(negedge clk);
      end
      chk("rstw_req_seen", 32'(seen), 32'd1);
      reset          = 1'b1;
      bus.fetchValid = 1'b0;
      #1;
      chk("rstw_req", 32'(bus.memRequest), 32'd0);
      chk("rstw_ready", 32'(bus.fetchReady), 32'd0);
      @(negedge clk);
      reset            = 1'b0;
      bus.memReceived  = 1'b1;
      bus.memCacheData = line_data(32'h18);
      exp_hit  = 0;
      exp_miss = 0;
      #1;
      chk_counts("rstw");
      chk("rstw_req_after", 32'(bus.memRequest), 32'd0);
      chk("rstw_ready_after", 32'(bus.fetchReady), 32'd0);
      @(negedge clk);
      bus.memReceived = 1'b0;
      #1;
      chk("rstw_req_idle", 32'(bus.memRequest), 32'd0);
      fetch(32'h0, 0, 1'b0, 1, 3, "rstw_fetch0");
      fetch(32'h18, 0, 1'b0, 1, 3, "rstw_fetch18");

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
